arbitro_registrador: RTL

ARBITRO_REGISTRADOR -- requirements
Module: arbitro_registrador

---
 rtl/arbitro_registrador_pkg.sv | 14 +
 rtl/arbitro_registrador_if.sv | 32 +++
 rtl/arbitro_registrador_registrador_carga.sv | 37 +++
 rtl/arbitro_registrador.sv | 118 +++++++++++
 4 files changed

// File: rtl/arbitro_registrador_pkg.sv
// Shared definitions for the two-requester registered arbiter.
//   estado_t        : FSM state encoding (OCIOSO, CARREGA, CONFIRMA)
//   LARGURA_PADRAO  : default data width of the shared register
package arbitro_registrador_pkg;

   localparam int LARGURA_PADRAO = 8;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CARREGA  = 2'd1,
      CONFIRMA = 2'd2
   } estado_t;

endpackage

// File: rtl/arbitro_registrador_if.sv
// Handshake/data bundle between two requesters and the arbiter.
//   req0/req1, dado0/dado1   : requests and write data (requester side drives)
//   ack0/ack1                : write-complete acknowledges (arbiter drives)
//   ocupado, q, conta_cargas : busy flag, shared register, completed-load count
// Modports: master = requester side, slave = arbiter side.
interface arbitro_registrador_if
   import arbitro_registrador_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) ();

   logic               req0;
   logic               req1;
   logic [LARGURA-1:0] dado0;
   logic [LARGURA-1:0] dado1;
   logic               ack0;
   logic               ack1;
   logic               ocupado;
   logic [LARGURA-1:0] q;
   logic [7:0]         conta_cargas;

   modport master (
      output req0, req1, dado0, dado1,
      input  ack0, ack1, ocupado, q, conta_cargas
   );

   modport slave (
      input  req0, req1, dado0, dado1,
      output ack0, ack1, ocupado, q, conta_cargas
   );

endinterface

// File: rtl/arbitro_registrador_registrador_carga.sv
// registrador_carga: LARGURA-bit register with load enable, built as a
// hold/load 2:1 mux in front of each flip-flop.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears q
//   carga : load enable (1 = take d, 0 = hold)
//   d     : data in
//   q     : register contents
module registrador_carga
   import arbitro_registrador_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               carga,
   input  logic [LARGURA-1:0] d,
   output logic [LARGURA-1:0] q
);

   logic [LARGURA-1:0] r_q;
   logic [LARGURA-1:0] w_d_prox;

   always_comb begin
      w_d_prox = r_q;
      for (int i = 0; i < LARGURA; i++) begin
         w_d_prox[i] = carga ? d[i] : r_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= '0;
      else     r_q <= w_d_prox;
   end

   assign q = r_q;

endmodule

// File: rtl/arbitro_registrador.sv
// arbitro_registrador: arbitrates two four-phase write requesters onto one
// shared register, acknowledges the winner and counts completed loads.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : arbitro_registrador_if.slave (req/dado in, ack/ocupado/q/conta_cargas out)
// Build option: define ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise requester 0 wins every tie.
//
// state    | meaning
// ---------+-----------------------------------------------------
// OCIOSO   | idle, sampling requests, grant registered on exit
// CARREGA  | loading dado of the granted requester into q
// CONFIRMA | ack of granted requester high until its req drops
module arbitro_registrador
   import arbitro_registrador_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic                  clk,
   input  logic                  rst,
   arbitro_registrador_if.slave  bus
);

   estado_t            r_estado;
   estado_t            w_estado_prox;
   logic               r_gnt;
   logic               w_gnt_prox;
   logic               w_escolha;
   logic               w_req_gnt;
   logic               w_carga;
   logic               r_ack0;
   logic               r_ack1;
   logic [7:0]         r_conta;
   logic [LARGURA-1:0] w_dado_sel;
   logic [LARGURA-1:0] w_q;

`ifdef ROUND_ROBIN_EN
   logic r_ultimo;

   // on a tie the requester not served last wins
   always_comb begin
      if (bus.req0 && bus.req1) w_escolha = ~r_ultimo;
      else                      w_escolha = ~bus.req0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           r_ultimo <= 1'b1;
      else if (r_estado == OCIOSO && (bus.req0 || bus.req1)) r_ultimo <= w_escolha;
   end
`else
   always_comb begin
      w_escolha = ~bus.req0;
   end
`endif

   always_comb begin
      w_estado_prox = r_estado;
      w_gnt_prox    = r_gnt;
      w_carga       = 1'b0;
      w_req_gnt     = r_gnt ? bus.req1 : bus.req0;
      case (r_estado)
         OCIOSO: begin
            if (bus.req0 || bus.req1) begin
               w_gnt_prox    = w_escolha;
               w_estado_prox = CARREGA;
            end
         end
         CARREGA: begin
            w_carga       = 1'b1;
            w_estado_prox = CONFIRMA;
         end
         CONFIRMA: begin
            if (!w_req_gnt) w_estado_prox = OCIOSO;
         end
         default: w_estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado <= OCIOSO;
         r_gnt    <= 1'b0;
      end else begin
         r_estado <= w_estado_prox;
         r_gnt    <= w_gnt_prox;
      end
   end

   // acks are registered off the next state so they rise with the load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_conta <= 8'd0;
      end else begin
         r_ack0 <= (w_estado_prox == CONFIRMA) && !w_gnt_prox;
         r_ack1 <= (w_estado_prox == CONFIRMA) &&  w_gnt_prox;
         if (w_carga) r_conta <= r_conta + 8'd1;
      end
   end

   assign w_dado_sel = r_gnt ? bus.dado1 : bus.dado0;

   registrador_carga #(.LARGURA(LARGURA)) u_registrador (
      .clk   (clk),
      .rst   (rst),
      .carga (w_carga),
      .d     (w_dado_sel),
      .q     (w_q)
   );

   assign bus.q            = w_q;
   assign bus.ack0         = r_ack0;
   assign bus.ack1         = r_ack1;
   assign bus.ocupado      = (r_estado != OCIOSO);
   assign bus.conta_cargas = r_conta;

endmodule
